// File: rtl/bus_pkg.sv
// Shared serial-bus constants and slave state encoding.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package bus_pkg;

  // Frame geometry, shared by master and slave
  localparam int BUS_ADDR_W     = 14;
  localparam int BUS_DATA_W     = 8;
  localparam int DATA_START_BIT = 6;   // address slot carrying write-data MSB
  localparam int ID_MSB         = 13;
  localparam int ID_LSB         = 12;

  typedef enum logic [2:0] {
    IDLE,
    RX,
    DECODE,
    MEM_WR,
    MEM_RD,
    TX_VALID,
    TX
  } slave_state_e;

  // True when the slave-select field of a full address equals the given id
  function automatic logic id_match(input logic [BUS_ADDR_W-1:0] addr,
                                    input logic [ID_MSB-ID_LSB:0] id);
    return addr[ID_MSB:ID_LSB] == id;
  endfunction

endpackage

// File: rtl/slave_mem.sv
// Single-port byte RAM with synchronous read and write.
// Latency: read data valid one clock after re; write lands on the same edge as we.
// Backpressure: none; accepts an access every cycle.
module slave_mem #(
  parameter int    AW   = 12,
  parameter string INIT = ""
) (
  input  logic          clock,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  // Synchronous write and registered read port
  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/bus_slave.sv
// Serial bus slave: deserialises address/write-data frames, accesses local RAM, serialises read data.
// Latency: last address bit at cycle N -> slave_valid at N+3, read bits N+4..N+11; write lands end of N+2.
// Backpressure: slave_ready low from first sampled bit until back in IDLE; valid low mid-frame pauses RX.
module bus_slave #(
  parameter logic [1:0] SLAVE_ID = 2'd0,
  parameter int         MEM_AW   = 12,
  parameter string      MEM_INIT = ""
) (
  input  logic clock,
  input  logic reset,
  input  logic valid,
  input  logic write_en,
  input  logic addr_rx,
  input  logic data_rx,
  output logic data_tx,
  output logic slave_valid,
  output logic slave_ready
);
  import bus_pkg::*;

  localparam logic [3:0] LAST_ADDR_BIT = 4'(BUS_ADDR_W - 1);
  localparam logic [3:0] FIRST_DATA_BIT = 4'(DATA_START_BIT);
  localparam logic [3:0] LAST_TX_BIT = 4'(BUS_DATA_W);

  slave_state_e          state;
  logic [3:0]            bit_cnt;
  logic [BUS_ADDR_W-1:0] addr_sr;
  logic [BUS_DATA_W-1:0] data_sr;
  logic [BUS_DATA_W-1:0] tx_sr;
  logic                  we_r;

  logic                  mem_we;
  logic                  mem_re;
  logic [BUS_DATA_W-1:0] mem_rdata;

  // RAM strobes decoded from the state register; the read is launched in
  // DECODE so its registered data is ready to load into tx_sr on MEM_RD exit
  always_comb begin
    mem_we = (state == MEM_WR);
    mem_re = (state == DECODE);
  end

  slave_mem #(
    .AW   (MEM_AW),
    .INIT (MEM_INIT)
  ) u_mem (
    .clock (clock),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (addr_sr[MEM_AW-1:0]),
    .wdata (data_sr),
    .rdata (mem_rdata)
  );

  // Frame receive, decode, memory access and serial transmit FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      addr_sr     <= '0;
      data_sr     <= '0;
      tx_sr       <= '0;
      we_r        <= 1'b0;
      data_tx     <= 1'b0;
      slave_valid <= 1'b0;
      slave_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            addr_sr     <= {addr_sr[BUS_ADDR_W-2:0], addr_rx};
            we_r        <= write_en;
            bit_cnt     <= 4'd1;
            slave_ready <= 1'b0;
            state       <= RX;
          end
        end

        RX: begin
          // valid low holds everything: the master may split a frame
          if (valid) begin
            addr_sr <= {addr_sr[BUS_ADDR_W-2:0], addr_rx};
            if (bit_cnt >= FIRST_DATA_BIT)
              data_sr <= {data_sr[BUS_DATA_W-2:0], data_rx};
            if (bit_cnt == LAST_ADDR_BIT) begin
              bit_cnt <= '0;
              state   <= DECODE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end

        DECODE: begin
          if (!id_match(addr_sr, SLAVE_ID)) begin
            slave_ready <= 1'b1;
            state       <= IDLE;
          end else if (we_r) begin
            state <= MEM_WR;
          end else begin
            state <= MEM_RD;
          end
        end

        MEM_WR: begin
          slave_ready <= 1'b1;
          state       <= IDLE;
        end

        MEM_RD: begin
          tx_sr       <= mem_rdata;
          slave_valid <= 1'b1;
          data_tx     <= 1'b0;
          state       <= TX_VALID;
        end

        TX_VALID: begin
          slave_valid <= 1'b0;
          data_tx     <= tx_sr[BUS_DATA_W-1];
          tx_sr       <= {tx_sr[BUS_DATA_W-2:0], 1'b0};
          bit_cnt     <= 4'd1;
          state       <= TX;
        end

        TX: begin
          if (bit_cnt == LAST_TX_BIT) begin
            data_tx     <= 1'b0;
            bit_cnt     <= '0;
            slave_ready <= 1'b1;
            state       <= IDLE;
          end else begin
            data_tx <= tx_sr[BUS_DATA_W-1];
            tx_sr   <= {tx_sr[BUS_DATA_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
          end
        end

        default: begin
          slave_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_slave.sv
// Directed bench for bus_slave: two instances (SLAVE_ID 0 and 1) share the serial inputs.
// Latency: expectations are cycle-exact relative to the last address bit.
// Backpressure: frames are only issued when the addressed slave is idle.
module tb_bus_slave;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic valid = 1'b0;
  logic write_en = 1'b0;
  logic addr_rx = 1'b0;
  logic data_rx = 1'b0;
  logic [1:0] data_tx_w;
  logic [1:0] slave_valid_w;
  logic [1:0] slave_ready_w;

  int n_checks = 0;
  int n_pass = 0;

  bus_slave #(.SLAVE_ID(2'd0), .MEM_AW(12), .MEM_INIT("")) dut0 (
    .clock       (clock),
    .reset       (reset),
    .valid       (valid),
    .write_en    (write_en),
    .addr_rx     (addr_rx),
    .data_rx     (data_rx),
    .data_tx     (data_tx_w[0]),
    .slave_valid (slave_valid_w[0]),
    .slave_ready (slave_ready_w[0])
  );

  bus_slave #(.SLAVE_ID(2'd1), .MEM_AW(12), .MEM_INIT("")) dut1 (
    .clock       (clock),
    .reset       (reset),
    .valid       (valid),
    .write_en    (write_en),
    .addr_rx     (addr_rx),
    .data_rx     (data_rx),
    .data_tx     (data_tx_w[1]),
    .slave_valid (slave_valid_w[1]),
    .slave_ready (slave_ready_w[1])
  );

  always #5 clock = ~clock;

  // Drive one 14-bit frame; the last bit is on the wires when this returns.
  // Optional pause of 'gap' cycles before bit index split_at, with junk on the lines.
  task automatic send_frame(input logic we, input logic [13:0] addr,
                            input logic [7:0] data, input int split_at, input int gap);
    for (int i = 0; i < 14; i++) begin
      if (i == split_at) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clock);
          valid = 1'b0;
          addr_rx = g[0];
          data_rx = ~g[0];
          n_checks++;
          if (slave_ready_w[0] !== 1'b0)
            $display("FAIL split_gap_ready gap=%0d got=%b exp=0", g, slave_ready_w[0]);
          else n_pass++;
        end
      end
      @(negedge clock);
      valid = 1'b1;
      write_en = (i == 0) ? we : ~we;
      addr_rx = addr[13-i];
      data_rx = (i >= 6) ? data[13-i] : 1'b1;
    end
  endtask

  task automatic check_write(input int sel, input string name);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      if (k == 1) begin valid = 1'b0; addr_rx = 1'b0; data_rx = 1'b0; end
      n_checks++;
      if (slave_ready_w[sel] !== (k == 3))
        $display("FAIL %s ready cyc=N+%0d got=%b exp=%b", name, k, slave_ready_w[sel], (k == 3));
      else n_pass++;
    end
  endtask

  task automatic check_read(input int sel, input logic [7:0] exp, input string name);
    logic [2:0] got, want;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (k == 1) begin valid = 1'b0; write_en = 1'b0; addr_rx = 1'b0; data_rx = 1'b0; end
      want[2] = (k == 3);
      want[1] = (k >= 4 && k <= 11) ? exp[11-k] : 1'b0;
      want[0] = (k == 12);
      got = {slave_valid_w[sel], data_tx_w[sel], slave_ready_w[sel]};
      n_checks++;
      if (got !== want)
        $display("FAIL %s {valid,tx,ready} cyc=N+%0d got=%b exp=%b", name, k, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++;
    if ({data_tx_w, slave_valid_w, slave_ready_w} !== 6'b00_00_11)
      $display("FAIL reset_outputs got tx=%b sv=%b rdy=%b exp tx=00 sv=00 rdy=11",
               data_tx_w, slave_valid_w, slave_ready_w);
    else n_pass++;
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({data_tx_w, slave_valid_w, slave_ready_w} !== 6'b00_00_11)
      $display("FAIL post_reset_idle got tx=%b sv=%b rdy=%b exp tx=00 sv=00 rdy=11",
               data_tx_w, slave_valid_w, slave_ready_w);
    else n_pass++;
  endtask

  task automatic test_write_read();
    send_frame(1'b1, 14'h0123, 8'hA5, -1, 0);
    check_write(0, "wr_0123");
    send_frame(1'b0, 14'h0123, 8'h00, -1, 0);
    check_read(0, 8'hA5, "rd_0123");
  endtask

  task automatic test_split();
    send_frame(1'b1, 14'h0FFF, 8'h3C, 2, 5);
    check_write(0, "wr_split_0fff");
    send_frame(1'b0, 14'h0FFF, 8'h00, -1, 0);
    check_read(0, 8'h3C, "rd_split_0fff");
  endtask

  task automatic test_id_mismatch();
    logic [1:0] got;
    send_frame(1'b1, 14'h1010, 8'h5A, -1, 0);
    check_write(1, "wr_id1_1010");
    // Local address 0x010 on the ID-1 slave must survive a frame tagged for ID 0
    send_frame(1'b1, 14'h0010, 8'hFF, -1, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      if (k == 1) begin valid = 1'b0; addr_rx = 1'b0; data_rx = 1'b0; end
      got = {slave_valid_w[1], slave_ready_w[1]};
      n_checks++;
      if (got !== {1'b0, (k >= 2)})
        $display("FAIL id_mismatch {valid,ready} cyc=N+%0d got=%b exp=%b", k, got, {1'b0, (k >= 2)});
      else n_pass++;
    end
    send_frame(1'b0, 14'h1010, 8'h00, -1, 0);
    check_read(1, 8'h5A, "rd_id1_unchanged");
    send_frame(1'b0, 14'h0010, 8'h00, -1, 0);
    check_read(0, 8'hFF, "rd_id0_0010");
  endtask

  task automatic test_reset_mid_tx();
    logic [2:0] got;
    send_frame(1'b0, 14'h0123, 8'h00, -1, 0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      if (k == 1) begin valid = 1'b0; addr_rx = 1'b0; data_rx = 1'b0; end
    end
    n_checks++;
    if (data_tx_w[0] !== 1'b1)
      $display("FAIL pre_abort_bit2 got=%b exp=1", data_tx_w[0]);
    else n_pass++;
    #1 reset = 1'b1;
    #1;
    got = {data_tx_w[0], slave_valid_w[0], slave_ready_w[0]};
    n_checks++;
    if (got !== 3'b001)
      $display("FAIL abort_outputs {tx,valid,ready} got=%b exp=001", got);
    else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    send_frame(1'b0, 14'h0123, 8'h00, -1, 0);
    check_read(0, 8'hA5, "rd_after_abort");
  endtask

  task automatic test_back_to_back();
    send_frame(1'b1, 14'h0001, 8'h11, -1, 0);
    // valid stays high through DECODE and MEM_WR with junk that must be ignored
    for (int k = 1; k <= 2; k++) begin
      @(negedge clock);
      valid = 1'b1; write_en = 1'b0; addr_rx = 1'b1; data_rx = 1'b1;
      n_checks++;
      if (slave_ready_w[0] !== 1'b0)
        $display("FAIL b2b_busy cyc=N+%0d got=%b exp=0", k, slave_ready_w[0]);
      else n_pass++;
    end
    send_frame(1'b1, 14'h0002, 8'h22, -1, 0);
    check_write(0, "wr_b2b_2");
    send_frame(1'b0, 14'h0001, 8'h00, -1, 0);
    check_read(0, 8'h11, "rd_b2b_1");
    send_frame(1'b0, 14'h0002, 8'h00, -1, 0);
    check_read(0, 8'h22, "rd_b2b_2");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_split();
    test_id_mismatch();
    test_reset_mid_tx();
    test_back_to_back();
    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
